// File: rtl/des_key_sequencer_if.sv
// Engine-side channel of the DES key sequencer: key issue handshake plus in-order result return.
interface des_key_sequencer_if;
   logic [63:0] pt_out;
   logic        key_valid;
   logic        key_ready;
   logic [63:0] key_out;
   logic        res_valid;
   logic [63:0] res_ct;
   logic [63:0] res_key;

   modport master (
      output pt_out, key_valid, key_out,
      input  key_ready, res_valid, res_ct, res_key
   );

   modport slave (
      input  pt_out, key_valid, key_out,
      output key_ready, res_valid, res_ct, res_key
   );
endinterface

// File: rtl/des_key_sequencer.sv
// Brute-force DES key source: walks a 56-bit counter, issues odd-parity keys to a pipelined
// engine and watches the returned ciphertexts for the target.
module des_key_sequencer #(
   parameter logic [55:0] START_COUNT  = 56'h0,
   parameter logic [55:0] MAX_COUNT    = 56'hFF_FFFF_FFFF_FFFF,
   parameter int unsigned MAX_INFLIGHT = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       Start,
   input  logic [63:0]                plaintext,
   input  logic [63:0]                ciphertext,
   des_key_sequencer_if.master        eng_io,
   output logic [63:0]                Key,
   output logic                       keyFound,
   output logic                       exhausted,
   output logic                       busy,
   output logic [55:0]                count
);

   localparam int unsigned InflightW = $clog2(MAX_INFLIGHT + 1);
   localparam logic [InflightW-1:0] InflightMax = InflightW'(MAX_INFLIGHT);

   typedef enum logic [2:0] {StIdle, StIssue, StDrain, StFound, StExhausted} state_e;

   state_e                state_q, state_d;
   logic [55:0]           cand_q, cand_d;
   logic [55:0]           count_q, count_d;
   logic [InflightW-1:0]  inflight_q, inflight_d;
   logic [63:0]           key_out_q, key_out_d;
   logic                  key_valid_q, key_valid_d;
   logic [63:0]           pt_q, pt_d;
   logic [63:0]           ct_q, ct_d;
   logic [63:0]           key_q, key_d;

   logic accept;
   logic res_hit;
   logic match;

   // Each 7-bit slice of the counter gets an odd-parity bit appended as the byte LSB.
   function automatic logic [63:0] expand(input logic [55:0] c);
      logic [63:0] k;
      for (int i = 0; i < 8; i++) begin
         k[8*i +: 8] = {c[7*i +: 7], ~^c[7*i +: 7]};
      end
      return k;
   endfunction

   assign accept  = key_valid_q & eng_io.key_ready;
   assign res_hit = eng_io.res_valid & ((state_q == StIssue) | (state_q == StDrain));
   assign match   = res_hit & (eng_io.res_ct == ct_q);

   always_comb begin
      state_d    = state_q;
      cand_d     = cand_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      pt_d       = pt_q;
      ct_d       = ct_q;
      key_d      = key_q;

      unique case (state_q)
         StIdle: begin
            cand_d     = START_COUNT;
            count_d    = '0;
            inflight_d = '0;
            if (Start) begin
               state_d = StIssue;
               pt_d    = plaintext;
               ct_d    = ciphertext;
            end
         end
         StIssue, StDrain: begin
            if (accept) begin
               cand_d  = (cand_q == MAX_COUNT) ? cand_q : cand_q + 56'd1;
               count_d = count_q + 56'd1;
            end
            inflight_d = inflight_q + InflightW'(accept) - InflightW'(res_hit);
            // A match outranks both the last-accept and the drain-complete transitions.
            if (match) begin
               state_d = StFound;
               key_d   = eng_io.res_key;
            end else if ((state_q == StIssue) && accept && (cand_q == MAX_COUNT)) begin
               state_d = StDrain;
            end else if ((state_q == StDrain) && (inflight_q == '0)) begin
               state_d = StExhausted;
            end
         end
         StFound, StExhausted: begin
            if (!Start) begin
               state_d    = StIdle;
               cand_d     = START_COUNT;
               count_d    = '0;
               inflight_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase

      // Registered issue stage: valid only once ISSUE is settled and the window has room.
      key_valid_d = (state_q == StIssue) && (state_d == StIssue) && (inflight_d < InflightMax);
      key_out_d   = (state_d == StIssue) ? expand(cand_d) : key_out_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cand_q      <= START_COUNT;
         count_q     <= '0;
         inflight_q  <= '0;
         key_out_q   <= '0;
         key_valid_q <= 1'b0;
         pt_q        <= '0;
         ct_q        <= '0;
         key_q       <= '0;
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         count_q     <= count_d;
         inflight_q  <= inflight_d;
         key_out_q   <= key_out_d;
         key_valid_q <= key_valid_d;
         pt_q        <= pt_d;
         ct_q        <= ct_d;
         key_q       <= key_d;
      end
   end

   assign eng_io.pt_out    = pt_q;
   assign eng_io.key_valid = key_valid_q;
   assign eng_io.key_out   = key_out_q;
   assign Key              = key_q;
   assign keyFound         = (state_q == StFound);
   assign exhausted        = (state_q == StExhausted);
   assign busy             = (state_q == StIssue) || (state_q == StDrain);
   assign count            = count_q;

endmodule
